// File: rtl/rvvi_depacketizer.sv
// rtl/rvvi_depacketizer.sv - RVVI Ethernet frame receiver
// Buffers one frame of 32-bit words, checks length/header/strobes, presents the record under valid/ready.
module rvvi_depacketizer #(
  parameter int          XLEN     = 64,
  parameter int          MAX_CSRS = 5,
  parameter logic [47:0] DST_MAC  = 48'h8F54_0000_1654,
  parameter logic [15:0] ETH_TYPE = 16'h005c,
  localparam int RW          = 72 + 5*XLEN + MAX_CSRS*(XLEN + 16),
  localparam int NB          = 112 + RW,
  localparam int FB          = NB + (32 - NB % 32),
  localparam int FRAME_WORDS = FB / 32
) (
  input  logic          m_axi_aclk,
  input  logic          m_axi_areset,
  input  logic [31:0]   RvviAxiRdata,
  input  logic [3:0]    RvviAxiRstrb,
  input  logic          RvviAxiRlast,
  input  logic          RvviAxiRvalid,
  output logic          RvviAxiRready,
  output logic [RW-1:0] rvvi,
  output logic          valid,
  input  logic          ready,
  output logic [31:0]   FrameCount,
  output logic [31:0]   DropCount,
  output logic [2:0]    FrameErr
);

  localparam logic [9:0] LAST_WC = 10'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {S_RECV = 2'd0, S_DRAIN = 2'd1, S_HOLD = 2'd2} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [9:0]      r_word_count;
  logic [FB-1:0]   r_buf;
  logic            r_strb_bad;
  logic [FB-1:0]   w_frame;
  logic            w_accept;
  logic            w_deliver;
  logic            w_at_end;
  logic            w_hdr_ok;
  logic            w_strb_ok;
  logic            w_good;
  logic            w_recv_last;
  logic            w_overlong;
  logic            w_drain_done;
  logic            w_drop;
  logic            w_clear;

  assign w_accept  = RvviAxiRvalid & RvviAxiRready;
  assign w_deliver = valid & ready;
  assign w_at_end  = (r_word_count == LAST_WC);

  // Header check sees the stored words with the incoming word merged in, so it works at any last position.
  always_comb begin
    w_frame = r_buf;
    for (int i = 0; i < FRAME_WORDS; i++) begin
      if (r_word_count == 10'(i)) w_frame[32*i +: 32] = RvviAxiRdata;
    end
  end

  assign w_hdr_ok     = (w_frame[95:48] == DST_MAC) && (w_frame[111:96] == ETH_TYPE);
  assign w_strb_ok    = !r_strb_bad && (RvviAxiRstrb == 4'hF);
  assign w_good       = w_at_end & w_hdr_ok & w_strb_ok;
  assign w_recv_last  = (r_state == S_RECV) & w_accept & RvviAxiRlast;
  assign w_overlong   = (r_state == S_RECV) & w_accept & ~RvviAxiRlast & w_at_end;
  assign w_drain_done = (r_state == S_DRAIN) & w_accept & RvviAxiRlast;
  assign w_drop       = w_recv_last & ~w_good;
  assign w_clear      = w_recv_last | w_drain_done | w_deliver;

  assign rvvi = r_buf[111+RW:112];

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) r_state <= S_RECV;
    else              r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RECV: begin
        if (w_recv_last && w_good) w_next_state = S_HOLD;
        else if (w_overlong)       w_next_state = S_DRAIN;
      end
      S_DRAIN: if (w_drain_done) w_next_state = S_RECV;
      S_HOLD:  if (ready)        w_next_state = S_RECV;
      default: w_next_state = S_RECV;
    endcase
  end

  always_comb begin
    RvviAxiRready = (r_state != S_HOLD);
    valid         = (r_state == S_HOLD);
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      r_word_count <= '0;
      r_strb_bad   <= 1'b0;
      r_buf        <= '0;
    end else begin
      if (w_clear)       r_word_count <= '0;
      else if (w_accept) r_word_count <= r_word_count + 10'd1;
      if (w_clear)
        r_strb_bad <= 1'b0;
      else if (w_accept && (r_state == S_RECV) && (RvviAxiRstrb != 4'hF))
        r_strb_bad <= 1'b1;
      // Drained words are never stored, so the buffer only changes in RECV.
      if (w_accept && (r_state == S_RECV)) r_buf <= w_frame;
    end
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      FrameCount <= '0;
      DropCount  <= '0;
      FrameErr   <= '0;
    end else begin
      if (w_deliver)                FrameCount <= FrameCount + 32'd1;
      if (w_drop || w_drain_done)   DropCount  <= DropCount + 32'd1;
      if (w_drop)                   FrameErr   <= FrameErr | {~w_strb_ok, ~w_hdr_ok, ~w_at_end};
      else if (w_overlong)          FrameErr   <= FrameErr | 3'b001;
    end
  end

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// tb/tb_rvvi_depacketizer.sv - directed and loopback bench for rvvi_depacketizer
// Frames are built by the bench from a record, header fields and zero pad.
module tb_rvvi_depacketizer;

  localparam int          XLEN        = 64;
  localparam int          MAX_CSRS    = 5;
  localparam int          RW          = 792;
  localparam int          FRAME_WORDS = 29;
  localparam int          FB          = 928;
  localparam logic [47:0] DST         = 48'h8F54_0000_1654;
  localparam logic [47:0] SRC         = 48'h0002_B3C4_D5E6;
  localparam logic [15:0] ETH         = 16'h005c;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   RvviAxiRdata = '0;
  logic [3:0]    RvviAxiRstrb = 4'hF;
  logic          RvviAxiRlast = 1'b0;
  logic          RvviAxiRvalid = 1'b0;
  logic          RvviAxiRready;
  logic [RW-1:0] rvvi;
  logic          valid;
  logic          ready = 1'b1;
  logic [31:0]   FrameCount;
  logic [31:0]   DropCount;
  logic [2:0]    FrameErr;

  int errors = 0;
  int checks = 0;
  int gap_pct = 0;

  rvvi_depacketizer #(.XLEN(XLEN), .MAX_CSRS(MAX_CSRS)) dut (
    .m_axi_aclk   (clk),
    .m_axi_areset (rst),
    .RvviAxiRdata (RvviAxiRdata),
    .RvviAxiRstrb (RvviAxiRstrb),
    .RvviAxiRlast (RvviAxiRlast),
    .RvviAxiRvalid(RvviAxiRvalid),
    .RvviAxiRready(RvviAxiRready),
    .rvvi         (rvvi),
    .valid        (valid),
    .ready        (ready),
    .FrameCount   (FrameCount),
    .DropCount    (DropCount),
    .FrameErr     (FrameErr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [FB-1:0] build_frame(input logic [RW-1:0] rec, input logic [47:0] dst,
                                                input logic [15:0] eth);
    logic [FB-1:0] f;
    f = '0;
    f[47:0]        = SRC;
    f[95:48]       = dst;
    f[111:96]      = eth;
    f[111+RW:112]  = rec;
    return f;
  endfunction

  function automatic logic [RW-1:0] inc_record();
    logic [RW-1:0] r;
    for (int k = 0; k < RW/8; k++) r[8*k +: 8] = 8'(k);
    return r;
  endfunction

  function automatic logic [RW-1:0] rand_record();
    logic [RW+7:0] r;
    for (int k = 0; k < (RW+8)/32; k++) r[32*k +: 32] = $urandom;
    return r[RW-1:0];
  endfunction

  task automatic send_word(input logic [31:0] d, input logic [3:0] s, input logic l);
    int waited;
    waited = 0;
    if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      RvviAxiRvalid = 1'b0;
      @(posedge clk); #1;
    end
    RvviAxiRdata  = d;
    RvviAxiRstrb  = s;
    RvviAxiRlast  = l;
    RvviAxiRvalid = 1'b1;
    while (RvviAxiRready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (waited >= 50) begin
      errors++;
      $display("FAIL word_accept_timeout: RvviAxiRready=%b after %0d cycles, required 1", RvviAxiRready, waited);
    end
    @(posedge clk); #1;
    RvviAxiRvalid = 1'b0;
    RvviAxiRlast  = 1'b0;
    RvviAxiRstrb  = 4'hF;
  endtask

  task automatic send_frame(input logic [FB-1:0] f, input int nwords, input int bad_strb_idx);
    logic [31:0] d;
    for (int i = 0; i < nwords; i++) begin
      d = (i < FRAME_WORDS) ? f[32*i +: 32] : $urandom;
      send_word(d, (i == bad_strb_idx) ? 4'h7 : 4'hF, i == nwords - 1);
    end
  endtask

  task automatic expect_no_valid(input string name, input int cycles);
    logic seen;
    seen = valid;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      seen |= valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL %s_no_valid: valid observed=%b, required 0", name, seen);
    end
  endtask

  task automatic deliver_good(input string name, input logic [31:0] exp_fc);
    logic [RW-1:0] rec;
    rec = inc_record();
    ready = 1'b1;
    send_frame(build_frame(rec, DST, ETH), FRAME_WORDS, -1);
    checks++;
    if (valid !== 1'b1 || rvvi !== rec) begin
      errors++;
      $display("FAIL %s_deliver: valid=%b rvvi=%h, required valid=1 rvvi=%h", name, valid, rvvi, rec);
    end
    @(posedge clk); #1;
    checks++;
    if (FrameCount !== exp_fc) begin
      errors++;
      $display("FAIL %s_framecount: FrameCount=%0d, required %0d", name, FrameCount, exp_fc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (RvviAxiRready !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: RvviAxiRready=%b valid=%b, required 1/0", RvviAxiRready, valid);
    end
    checks++;
    if (rvvi !== '0) begin
      errors++;
      $display("FAIL reset_rvvi: rvvi nonzero, required 0");
    end
    checks++;
    if (FrameCount !== 32'd0 || DropCount !== 32'd0 || FrameErr !== 3'b000) begin
      errors++;
      $display("FAIL reset_counters: FrameCount=%0d DropCount=%0d FrameErr=%b, required 0/0/000",
               FrameCount, DropCount, FrameErr);
    end
  endtask

  task automatic test_good_frame();
    logic [RW-1:0] rec;
    rec = inc_record();
    ready = 1'b1;
    send_frame(build_frame(rec, DST, ETH), FRAME_WORDS, -1);
    checks++;
    if (valid !== 1'b1 || RvviAxiRready !== 1'b0) begin
      errors++;
      $display("FAIL good_latency: valid=%b RvviAxiRready=%b, required 1/0", valid, RvviAxiRready);
    end
    checks++;
    if (rvvi !== rec) begin
      errors++;
      $display("FAIL good_rvvi: rvvi=%h, required %h", rvvi, rec);
    end
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b0 || RvviAxiRready !== 1'b1) begin
      errors++;
      $display("FAIL good_one_cycle: valid=%b RvviAxiRready=%b, required 0/1", valid, RvviAxiRready);
    end
    checks++;
    if (FrameCount !== 32'd1) begin
      errors++;
      $display("FAIL good_framecount: FrameCount=%0d, required 1", FrameCount);
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] rec;
    int bad;
    rec = inc_record();
    rec[7:0] = 8'hA5;
    ready = 1'b0;
    send_frame(build_frame(rec, DST, ETH), FRAME_WORDS, -1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid !== 1'b1 || RvviAxiRready !== 1'b0 || rvvi !== rec || FrameCount !== 32'd1) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d of 10 cycles unstable, required 0", bad);
    end
    ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b0 || FrameCount !== 32'd2) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b FrameCount=%0d, required 0/2", valid, FrameCount);
    end
  endtask

  task automatic test_header_errors();
    ready = 1'b1;
    send_frame(build_frame(inc_record(), DST, 16'h0800), FRAME_WORDS, -1);
    checks++;
    if (DropCount !== 32'd1 || FrameErr !== 3'b010) begin
      errors++;
      $display("FAIL header_ethtype: DropCount=%0d FrameErr=%b, required 1/010", DropCount, FrameErr);
    end
    expect_no_valid("header_ethtype", 3);
    send_frame(build_frame(inc_record(), DST ^ 48'h0000_0100_0000, ETH), FRAME_WORDS, -1);
    checks++;
    if (DropCount !== 32'd2 || FrameErr !== 3'b010) begin
      errors++;
      $display("FAIL header_dstmac: DropCount=%0d FrameErr=%b, required 2/010", DropCount, FrameErr);
    end
    expect_no_valid("header_dstmac", 3);
  endtask

  task automatic test_length_errors();
    ready = 1'b1;
    send_frame(build_frame(inc_record(), DST, ETH), 21, -1);
    checks++;
    if (DropCount !== 32'd3 || FrameErr !== 3'b011) begin
      errors++;
      $display("FAIL length_short: DropCount=%0d FrameErr=%b, required 3/011", DropCount, FrameErr);
    end
    expect_no_valid("length_short", 2);
    deliver_good("after_short", 32'd3);
    send_frame(build_frame(inc_record(), DST, ETH), 35, -1);
    checks++;
    if (DropCount !== 32'd4 || FrameErr !== 3'b011 || RvviAxiRready !== 1'b1) begin
      errors++;
      $display("FAIL length_long: DropCount=%0d FrameErr=%b RvviAxiRready=%b, required 4/011/1",
               DropCount, FrameErr, RvviAxiRready);
    end
    expect_no_valid("length_long", 2);
    deliver_good("after_long", 32'd4);
  endtask

  task automatic test_strobe_error();
    ready = 1'b1;
    send_frame(build_frame(inc_record(), DST, ETH), FRAME_WORDS, 5);
    checks++;
    if (DropCount !== 32'd5 || FrameErr !== 3'b111 || FrameCount !== 32'd4) begin
      errors++;
      $display("FAIL strobe: DropCount=%0d FrameErr=%b FrameCount=%0d, required 5/111/4",
               DropCount, FrameErr, FrameCount);
    end
    expect_no_valid("strobe", 2);
  endtask

  task automatic test_loopback();
    logic [FB-1:0] f;
    logic [RW-1:0] rec;
    int bad;
    ready = 1'b1;
    f = build_frame(rand_record(), DST, ETH);
    send_frame(f, 10, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (FrameCount !== 32'd0 || DropCount !== 32'd0 || RvviAxiRready !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL loopback_reset: FrameCount=%0d DropCount=%0d RvviAxiRready=%b valid=%b, required 0/0/1/0",
               FrameCount, DropCount, RvviAxiRready, valid);
    end
    gap_pct = 20;
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      rec = rand_record();
      ready = 1'b0;
      send_frame(build_frame(rec, DST, ETH), FRAME_WORDS, -1);
      if (valid !== 1'b1 || rvvi !== rec) begin
        bad++;
        $display("FAIL loopback_record_%0d: valid=%b rvvi=%h, required valid=1 rvvi=%h", n, valid, rvvi, rec);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      ready = 1'b1;
      @(posedge clk); #1;
    end
    gap_pct = 0;
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (FrameCount !== 32'd100 || DropCount !== 32'd0 || FrameErr !== 3'b000) begin
      errors++;
      $display("FAIL loopback_counts: FrameCount=%0d DropCount=%0d FrameErr=%b, required 100/0/000",
               FrameCount, DropCount, FrameErr);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_backpressure();
    test_header_errors();
    test_length_errors();
    test_strobe_error();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
